// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction formats, opcodes and
// immediate range limits used by both the encoder and the decoder side.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
  localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
  localparam logic signed [63:0] IMMB_MIN  = -64'sd4096;
  localparam logic signed [63:0] IMMB_MAX  =  64'sd4094;
  localparam logic signed [63:0] IMMJ_MIN  = -64'sd1048576;
  localparam logic signed [63:0] IMMJ_MAX  =  64'sd1048574;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  function automatic logic imm_in_range(input logic signed [63:0] v,
                                        input logic signed [63:0] lo,
                                        input logic signed [63:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of inst_encoder.
interface inst_encoder_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [63:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational immediate legality check and 32-bit instruction packing.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]         fmt_i,
  input  logic signed [63:0] imm_i,
  input  logic [6:0]         opcode_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  output logic [31:0]        inst_o,
  output logic               legal_o
);

  // NOTE: defaults first so every path assigns both outputs; no latch inferred.
  always_comb begin
    inst_o  = '0;
    legal_o = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_R: begin
        legal_o = 1'b1;
        inst_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        legal_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
        inst_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_S: begin
        legal_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
        inst_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      end
      FMT_B: begin
        legal_o = imm_in_range(imm_i, IMMB_MIN, IMMB_MAX) && !imm_i[0];
        inst_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
      end
      FMT_U: begin
        // Value must be a sign-extended 32-bit quantity with a clear low page.
        legal_o = (imm_i[11:0] == 12'd0) && ((&imm_i[63:31]) || !(|imm_i[63:31]));
        inst_o  = {imm_i[31:12], rd_i, opcode_i};
      end
      FMT_J: begin
        legal_o = imm_in_range(imm_i, IMMJ_MIN, IMMJ_MAX) && !imm_i[0];
        inst_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Pipelined RISC-V instruction encoder: legality check, packing, and a
// one-entry output register with a sequential byte-address counter.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  inst_encoder_if.slave bus,
  output logic         err,
  output logic [7:0]   err_count
);

  logic [31:0]       packed_inst;
  logic              legal;
  enc_state_e        state_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              err_q;
  logic [7:0]        err_cnt_q;
  logic              accept;
  logic              load;
  logic              reject;
  logic              out_hs;

  imm_pack u_pack (
    .fmt_i    (bus.in_fmt),
    .imm_i    (bus.in_imm),
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct3_i (bus.in_funct3),
    .funct7_i (bus.in_funct7),
    .inst_o   (packed_inst),
    .legal_o  (legal)
  );

  assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = accept && legal;
  assign reject       = accept && !legal;
  assign out_hs       = (state_q == ST_FULL) && bus.out_ready;

  // A word loaded in the same cycle as a handshake takes the post-advance address.
  assign cnt_d = out_hs ? cnt_q + ADDR_W'(4) : cnt_q;

  // NOTE: non-blocking assignments keep every register update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      inst_q    <= '0;
      addr_q    <= ADDR_W'(BASE_ADDR);
      cnt_q     <= ADDR_W'(BASE_ADDR);
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        state_q <= ST_FULL;
        inst_q  <= packed_inst;
        addr_q  <= cnt_d;
      end else if (out_hs) begin
        state_q <= ST_EMPTY;
      end
      if (reject) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_inst  = inst_q;
  assign bus.out_addr  = addr_q;
  assign err           = err_q;
  assign err_count     = err_cnt_q;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RISC-V instruction encoder, the inverse of the datapath's immediate decoder. It accepts decoded fields (format, opcode, registers, funct3/funct7, and a 64-bit signed immediate), checks that the immediate is legal for the format, and packs a 32-bit instruction word. It sits between the test/boot program generator and the instruction memory write port, and emits each word with its target byte address on a valid/ready stream.

## Interface
Parameters:
- ADDR_W, 16: width of the instruction-memory byte address.
- BASE_ADDR, 0: address of the first emitted word (4-byte aligned).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle present.
- in_ready  out  1  encoder can take the bundle this cycle.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  in  7  instr[6:0].
- in_rd / in_rs1 / in_rs2  in  5 each  register indices.
- in_funct3  in  3.
- in_funct7  in  7  (R only).
- in_imm  in  64  signed immediate, byte offset for B/J, full value (low 12 bits zero) for U.
- out_valid  out  1  encoded word held.
- out_ready  in  1  consumer takes the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for out_inst.
- err  out  1  sticky; set on any rejected bundle.
- err_count  out  8  rejected bundles, saturates at 255.

## Operation
- Accept a bundle when in_valid && in_ready.
- Legality rules. A failing bundle is consumed and dropped: err is set, err_count increments, no output, and the address does not advance.
  - I and S: in_imm in [-2048, 2047].
  - B: in_imm in [-4096, 4094] and in_imm[0]=0.
  - J: in_imm in [-2^20, 2^20-2] and in_imm[0]=0.
  - U: in_imm[11:0]=0 and in_imm[63:31] all equal.
  - R: in_imm ignored.
  - fmt 6 or 7: always illegal.
- Packing:
  - R: {f7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Output register FSM:
  - EMPTY → FULL on a legal accept.
  - FULL → EMPTY on out_ready with no legal accept.
  - FULL → FULL on out_ready with a legal accept, which replaces the word the same cycle.
- in_ready = EMPTY || out_ready. This is combinational from out_ready; there is no other combinational input-to-output path.
- Address counter starts at BASE_ADDR and advances by 4 on each output handshake (out_valid && out_ready). It wraps modulo 2^ADDR_W.
- out_addr is the address of the word currently held. It is captured from the counter on load, and the counter accounts for a load and a handshake in the same cycle.

## Timing
- Latency: word visible on out_valid the cycle after a legal accept.
- Throughput: 1 word/cycle while out_ready is held high.
- Outputs held stable while out_valid && !out_ready.
- Reset values: out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, err_count=0, counter=BASE_ADDR, state EMPTY. in_ready=1 the cycle after reset.
- Reset mid-operation: the held word is discarded, and a handshake in the reset cycle has no effect.
- An illegal bundle arriving in the same cycle as an output handshake: the output drains normally, the error is counted, and nothing is loaded.
- err_count at 255 stays at 255; err clears only on rst.

## Structure
- Shared package riscv_pkg (reused by the decoder side):
  - format enum/constants (FMT_R..FMT_J).
  - opcode constants (OP_IMM=0010011, OP_BRANCH=1100011, OP_LUI=0110111, OP_JAL=1101111, OP_STORE=0100011, OP_JALR=1100111).
  - immediate range limits.
- One combinational sub-module, imm_pack. Inputs: fmt, imm, fields. Outputs: inst[31:0], legal. The top holds the FSM, output register, counter and error logic.

## Test plan
- beq x1,x2,-20 (fmt B, f3 0) → next cycle out_inst=0xFE2086E3, out_addr=BASE_ADDR.
- addi x5,x4,50 issued immediately after → out_inst=0x03220293, out_addr=BASE_ADDR+4, with no bubble while out_ready=1.
- lui x5 imm=0x1000 → 0x000012B7. jal with imm=5 → dropped, err=1, err_count=1, out_valid stays 0, address unchanged.
- addi imm=2048, then 300 illegal fmt=7 bundles → err_count saturates at 255, and a following legal word still gets the next sequential address.
- out_ready low for 3 cycles with a second bundle waiting → in_ready=0 and out_inst/out_addr stable. On release, both words emerge in order on consecutive cycles.
- ADDR_W=4, BASE_ADDR=12: two words → addresses 12 then 0 (wrap). Assert rst while FULL → out_valid=0, out_addr=12 next cycle.
